// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_ctrl_pkg
// Description : Shared definitions for the RAM access controller.
//               Holds the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  // Controller states. The encoding is fixed so that the state register can
  // be observed and decoded outside the block.
  typedef enum logic [1:0] {
    INIT    = 2'd0,  // zero-fill sweep after reset
    IDLE    = 2'd1,  // accepting requests
    RD_WAIT = 2'd2,  // RAM read in flight
    RESP    = 2'd3   // response held until the consumer takes it
  } state_t;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : ram_access_ctrl_if
// Description : CPU-side request/response handshake of the RAM access
//               controller.
//   req_valid   : request present                     (master -> slave)
//   req_ready   : controller accepts this cycle       (slave  -> master)
//   req_write   : 1 = write, 0 = read                 (master -> slave)
//   req_address : target entry                        (master -> slave)
//   req_wdata   : write data                          (master -> slave)
//   rsp_valid   : read data held on rsp_data          (slave  -> master)
//   rsp_ready   : consumer takes response             (master -> slave)
//   rsp_data    : read result                         (slave  -> master)
//   rsp_err     : address was out of range            (slave  -> master)
//   init_done   : zero-fill complete                  (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_access_ctrl_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_address;
  logic [SIZE-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [SIZE-1:0]   rsp_data;
  logic              rsp_err;
  logic              init_done;

  // CPU datapath side
  modport master (
    output req_valid, req_write, req_address, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_address, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );

endinterface : ram_access_ctrl_if
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_ctrl
// Description : Upstream controller for a single-port synchronous RAM with a
//               1-cycle registered read and write-first behaviour.
//               Zero-fills the RAM after reset, then serves CPU reads/writes
//               over a valid/ready handshake. Read data is returned through a
//               held response register with backpressure.
// Ports       :
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   bus            if   ram_access_ctrl_if.slave (request/response handshake)
//   ram_address    out  RAM address
//   ram_write_data out  RAM write data
//   ram_write_en   out  RAM write enable
//   ram_read_data  in   RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [SIZE-1:0]      ram_write_data,
  output logic                 ram_write_en,
  input  logic [SIZE-1:0]      ram_read_data
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_init_cnt;
  logic [ADDR_W-1:0]  r_addr_q;
  logic               r_err_q;
  logic               r_init_done;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [SIZE-1:0]    r_rsp_data;

  logic               w_in_range;
  logic               w_rd_accept;
  logic               w_init_last;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign w_in_range  = ({1'b0, bus.req_address} < c_depth);
  assign w_rd_accept = (r_state == IDLE) && bus.req_valid && !bus.req_write;
  assign w_init_last = (r_state == INIT) && (r_init_cnt == c_last);

  // --------------------------------------------------------------------------
  // Next state and RAM-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    ram_address    = r_addr_q;
    ram_write_data = '0;
    ram_write_en   = 1'b0;
    bus.req_ready  = 1'b0;

    case (r_state)
      INIT: begin
        ram_address  = r_init_cnt;
        ram_write_en = 1'b1;
        if (w_init_last) begin
          w_state_nxt = IDLE;
        end
      end

      IDLE: begin
        // ready depends on state only, never on req_valid
        bus.req_ready  = 1'b1;
        ram_address    = bus.req_address;
        ram_write_data = bus.req_wdata;
        if (bus.req_valid) begin
          if (bus.req_write) begin
            // out-of-range writes are dropped silently
            ram_write_en = w_in_range;
          end else begin
            w_state_nxt = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // RAM already registered the read at the accept edge; keep the
        // address stable so the read data stays valid this cycle.
        w_state_nxt = RESP;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, sweep counter, read context and response register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_addr_q    <= '0;
      r_err_q     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end

      // sticky until the next reset
      if (w_init_last) begin
        r_init_done <= 1'b1;
      end

      if (w_rd_accept) begin
        r_addr_q <= bus.req_address;
        r_err_q  <= !w_in_range;
      end

      if (r_state == RD_WAIT) begin
        r_rsp_data  <= r_err_q ? '0 : ram_read_data;
        r_rsp_err   <= r_err_q;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.init_done = r_init_done;

endmodule : ram_access_ctrl
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_ctrl
// Description : Self-checking bench for ram_access_ctrl (SIZE=8, DEPTH=12)
//               with a write-first, 1-cycle registered-read RAM model.
//               Read expectations go into a scoreboard queue when a read is
//               issued and are compared when the response handshake fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  localparam int c_size  = 8;
  localparam int c_depth = 12;
  localparam int c_aw    = 4;

  logic              clk;
  logic              rst;
  logic [c_aw-1:0]   ram_address;
  logic [c_size-1:0] ram_write_data;
  logic              ram_write_en;
  logic [c_size-1:0] ram_read_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard entry: {err, data}
  logic [8:0] sb_q[$];

  ram_access_ctrl_if #(.SIZE(c_size), .DEPTH(c_depth)) bus ();

  ram_access_ctrl #(.SIZE(c_size), .DEPTH(c_depth)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_write_en   (ram_write_en),
    .ram_read_data  (ram_read_data)
  );

  // RAM model: write-first, registered read. Array covers the full address
  // space; unswept entries start non-zero so forced zeros are visible.
  logic [7:0] mem [16] = '{default: 8'hFF};
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= ram_write_en ? ram_write_data : mem[ram_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard compare at the response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("sb_rsp_data", {24'd0, bus.rsp_data}, {24'd0, e[7:0]});
        check("sb_rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[8]});
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge.
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Counts rising edges until init_done; expects exactly exp_cycles.
  task automatic wait_init(input int exp_cycles);
    int n = 0;
    while (!bus.init_done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("init_latency", n, exp_cycles);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic exp_we);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_address = a;  bus.req_wdata = d;
    #1;
    check("wr_ready", {31'd0, bus.req_ready}, 32'd1);
    check("wr_we", {31'd0, ram_write_en}, {31'd0, exp_we});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Read with optional backpressure: rsp_ready held low for hold cycles
  // after rsp_valid rises.
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp_d,
                         input logic exp_e, input int hold);
    wait_ready();
    sb_q.push_back({exp_e, exp_d});
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = a;
    #1;
    check("rd_we", {31'd0, ram_write_en}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rdwait_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rdwait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("resp_ready", {31'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_data", {24'd0, bus.rsp_data}, {24'd0, exp_d});
      check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    check("back_idle", {31'd0, bus.req_ready}, 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;    // write data, or expected read data
    logic       exp_we;  // writes: expected ram_write_en
    logic       exp_err; // reads: expected rsp_err
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  8'hA5, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'd3,  8'hA5, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd13, 8'h3C, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd13, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'd0,  8'h11, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'd11, 8'h22, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  8'h11, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd11, 8'h22, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd15, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd7,  8'h5A, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'd7,  8'h5A, 1'b0, 1'b0};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_address = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // Reset and initial sweep
    @(posedge clk); #1;
    check("rst_init_done", {31'd0, bus.init_done}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    rst = 1'b0;
    check("init_we", {31'd0, ram_write_en}, 32'd1);
    check("init_addr0", {28'd0, ram_address}, 32'd0);
    check("init_ready", {31'd0, bus.req_ready}, 32'd0);
    wait_init(c_depth);
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int a = 0; a < c_depth; a++) do_read(4'(a), 8'h00, 1'b0, 0);

    // Table-driven read/write vectors (consecutive writes 4,5 have no gap)
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].exp_we);
      else           do_read(tbl[i].addr, tbl[i].data, tbl[i].exp_err, 0);
    end

    // Backpressure: rsp_ready low for 4 cycles
    do_read(4'd5, 8'h00, 1'b0, 4);

    // Reset while in RESP: pending response discarded
    wait_ready();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 4'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_resp_init_done", {31'd0, bus.init_done}, 32'd0);
    check("rst_resp_addr", {28'd0, ram_address}, 32'd0);
    wait_init(c_depth);

    // Write 0xA5 @3, then reset mid-sweep at count 6
    do_write(4'd3, 8'hA5, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("sweep_cnt6", {28'd0, ram_address}, 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("sweep_restart", {28'd0, ram_address}, 32'd0);
    check("sweep_rst_done", {31'd0, bus.init_done}, 32'd0);
    wait_init(c_depth);
    do_read(4'd3, 8'h00, 1'b0, 0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ram_access_ctrl
`default_nettype wire
